// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-FU result queues, round-robin pick, one
// registered broadcast per cycle to rename, reservation stations and ROB.
module cdb_arbiter #(
  parameter int NSRC   = 4,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic [NSRC-1:0]          req_valid_i,
  output logic [NSRC-1:0]          req_ready_o,
  input  logic [NSRC*TAG_W-1:0]    req_tag_i,
  input  logic [NSRC*DATA_W-1:0]   req_data_i,
  output logic                     cdb_en_o,
  output logic [TAG_W-1:0]         cdb_reg_addr_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output logic [1:0]               cdb_src_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = 2;

  logic [TAG_W-1:0]  tag_mem_q  [NSRC][DEPTH];
  logic [TAG_W-1:0]  tag_mem_d  [NSRC][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NSRC][DEPTH];
  logic [DATA_W-1:0] data_mem_d [NSRC][DEPTH];
  logic [PTR_W-1:0]  head_q  [NSRC];
  logic [PTR_W-1:0]  head_d  [NSRC];
  logic [PTR_W-1:0]  tail_q  [NSRC];
  logic [PTR_W-1:0]  tail_d  [NSRC];
  logic [CNT_W-1:0]  count_q [NSRC];
  logic [CNT_W-1:0]  count_d [NSRC];
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              cdb_en_q,   cdb_en_d;
  logic [TAG_W-1:0]  cdb_tag_q,  cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q,  cdb_src_d;

  logic [NSRC-1:0]   push_v;
  logic [NSRC-1:0]   pop_v;
  logic              win_valid;
  logic [SRC_W-1:0]  win_idx;
  logic [SRC_W-1:0]  scan_idx;

  // Handshake: a source transfers on an edge where req_valid_i and
  // req_ready_o are both high; ready looks only at the registered count,
  // so a pop in the same cycle never opens a slot early. Tag 0 completes
  // the handshake but is discarded, since x0 has no consumers.
  always_comb begin
    req_ready_o = '0;
    push_v      = '0;
    for (int i = 0; i < NSRC; i++) begin
      req_ready_o[i] = reset_i & ~flush_i & (count_q[i] < CNT_W'(DEPTH));
      push_v[i]      = req_valid_i[i] & req_ready_o[i] &
                       (req_tag_i[i*TAG_W +: TAG_W] != '0);
    end
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NSRC; i++) begin
      scan_idx = SRC_W'((int'(rr_ptr_q) + i) % NSRC);
      if (!win_valid && (count_q[scan_idx] != '0)) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    tag_mem_d  = tag_mem_q;
    data_mem_d = data_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rr_ptr_d   = rr_ptr_q;
    cdb_en_d   = 1'b0;
    cdb_tag_d  = cdb_tag_q;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    pop_v      = '0;
    if (flush_i) begin
      for (int i = 0; i < NSRC; i++) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end
    end else begin
      if (win_valid) begin
        pop_v[win_idx] = 1'b1;
        cdb_en_d       = 1'b1;
        cdb_tag_d      = tag_mem_q[win_idx][head_q[win_idx]];
        cdb_data_d     = data_mem_q[win_idx][head_q[win_idx]];
        cdb_src_d      = win_idx;
        rr_ptr_d       = SRC_W'((int'(win_idx) + 1) % NSRC);
      end
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      for (int i = 0; i < NSRC; i++) begin
        if (pop_v[i]) begin
          head_d[i] = head_q[i] + 1'b1;
        end
        if (push_v[i]) begin
          tag_mem_d[i][tail_q[i]]  = req_tag_i[i*TAG_W +: TAG_W];
          data_mem_d[i][tail_q[i]] = req_data_i[i*DATA_W +: DATA_W];
          tail_d[i]                = tail_q[i] + 1'b1;
        end
        count_d[i] = count_q[i] + CNT_W'(push_v[i]) - CNT_W'(pop_v[i]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NSRC; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          tag_mem_q[i][j]  <= '0;
          data_mem_q[i][j] <= '0;
        end
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_ptr_q   <= '0;
      cdb_en_q   <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
    end else begin
      tag_mem_q  <= tag_mem_d;
      data_mem_q <= data_mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      cdb_en_q   <= cdb_en_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  assign cdb_en_o       = cdb_en_q;
  assign cdb_reg_addr_o = cdb_tag_q;
  assign cdb_data_o     = cdb_data_q;
  assign cdb_src_o      = cdb_src_q;

endmodule
